muldiv_stall_ctrl: RTL and testbench

- Sequences the iterative multiply/divide unit in the EX stage of the 5-stage RV32IM pipeline.
- On a multi-cycle op in EX it freezes F/D/E, injects bubbles into M, times the unit by op-dependent latency counters, and releases the pipeline the cycle the result is ready.
- Handles kill from an older trapping instruction in M.
- Its stall and bubble outputs are ORed by the pipeline top with the hazard unit's load-use stall and branch flush.

---
 rtl/muldiv_pkg.sv | 30 +++
 rtl/md_lat_counter.sv | 27 ++
 rtl/muldiv_stall_ctrl.sv | 127 ++++++++++++
 tb/tb_muldiv_stall_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and latency helper for the multiply/divide stall controller.
package muldiv_pkg;

    localparam int unsigned MUL_LAT_DEF = 3;
    localparam int unsigned DIV_LAT_DEF = 32;
    localparam int unsigned CNT_W_DEF   = 6;

    typedef enum logic [1:0] {
        MD_MUL = 2'b00,
        MD_DIV = 2'b01,
        MD_REM = 2'b10,
        MD_RSV = 2'b11
    } md_op_t;

    typedef enum logic [1:0] {
        MD_IDLE  = 2'b00,
        MD_BUSY  = 2'b01,
        MD_ABORT = 2'b10
    } md_state_t;

    // Divide by zero short-circuits to a single-cycle result.
    function automatic int unsigned mdLatency(md_op_t op, logic divZero,
                                              int unsigned mulLat, int unsigned divLat);
        case (op)
            MD_DIV, MD_REM: mdLatency = divZero ? 32'd1 : divLat;
            default:        mdLatency = mulLat;
        endcase
    endfunction

endpackage

// File: rtl/md_lat_counter.sv
// Loadable down-counter that parks at zero; zero flag is combinational.
module md_lat_counter #(
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] loadVal,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= loadVal;
        end else if (dec && !zero) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/muldiv_stall_ctrl.sv
// EX-stage sequencer for the iterative mul/div unit: stalls F/D/E and bubbles M while busy.
// Optional MULDIV_PERF_EN adds saturating stall-cycle and kill counters.
module muldiv_stall_ctrl
    import muldiv_pkg::*;
#(
    parameter int unsigned MUL_LAT = MUL_LAT_DEF,
    parameter int unsigned DIV_LAT = DIV_LAT_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       MdValidE,
    input  logic [1:0] MdOpE,
    input  logic       DivZeroE,
    input  logic       KillE,
    output logic       MdStart,
    output logic       MdAbort,
    output logic       MdStallF,
    output logic       MdStallD,
    output logic       MdStallE,
    output logic       MdFlushM,
    output logic       MdResultValidE,
    output logic       MdBusy
`ifdef MULDIV_PERF_EN
    ,
    output logic [31:0] MdStallCycles,
    output logic [15:0] MdKillCount
`endif
);

    md_state_t        state;
    md_state_t        stateNext;
    logic             cntLoad;
    logic             cntDec;
    logic             cntZero;
    logic             stall;
    logic [CNT_W-1:0] cntLoadVal;

    assign cntLoadVal = CNT_W'(mdLatency(md_op_t'(MdOpE), DivZeroE, MUL_LAT, DIV_LAT) - 32'd1);

    md_lat_counter #(.CNT_W(CNT_W)) u_lat (
        .clk    (clk),
        .reset  (reset),
        .load   (cntLoad),
        .dec    (cntDec),
        .loadVal(cntLoadVal),
        .zero   (cntZero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= MD_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Kill outranks completion; ABORT is a dead cycle while the trap flush clears EX.
    always_comb begin
        stateNext      = state;
        MdStart        = 1'b0;
        MdAbort        = 1'b0;
        MdResultValidE = 1'b0;
        stall          = 1'b0;
        cntLoad        = 1'b0;
        cntDec         = 1'b0;
        case (state)
            MD_IDLE: begin
                if (MdValidE && !KillE) begin
                    MdStart   = 1'b1;
                    stall     = 1'b1;
                    cntLoad   = 1'b1;
                    stateNext = MD_BUSY;
                end
            end
            MD_BUSY: begin
                if (KillE) begin
                    MdAbort   = 1'b1;
                    stall     = 1'b1;
                    stateNext = MD_ABORT;
                end else if (!cntZero) begin
                    stall  = 1'b1;
                    cntDec = 1'b1;
                end else begin
                    MdResultValidE = 1'b1;
                    stateNext      = MD_IDLE;
                end
            end
            MD_ABORT: begin
                stateNext = MD_IDLE;
            end
            default: begin
                stateNext = MD_IDLE;
            end
        endcase
        // Outputs read as zero for the whole time reset is held.
        if (reset) begin
            MdStart        = 1'b0;
            MdAbort        = 1'b0;
            MdResultValidE = 1'b0;
            stall          = 1'b0;
        end
    end

    assign MdStallF = stall;
    assign MdStallD = stall;
    assign MdStallE = stall;
    assign MdFlushM = stall;
    assign MdBusy   = (state != MD_IDLE) && !reset;

`ifdef MULDIV_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            MdStallCycles <= '0;
            MdKillCount   <= '0;
        end else begin
            if (stall && (MdStallCycles != '1)) begin
                MdStallCycles <= MdStallCycles + 32'd1;
            end
            if (MdAbort && (MdKillCount != '1)) begin
                MdKillCount <= MdKillCount + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_muldiv_stall_ctrl.sv
// Randomized + directed bench for muldiv_stall_ctrl against a time-stamped occupancy model.
module tb_muldiv_stall_ctrl;

    localparam int unsigned MUL_LAT = 3;
    localparam int unsigned DIV_LAT = 32;

    localparam int S_START = 7;
    localparam int S_ABORT = 6;
    localparam int S_STALL = 5;
    localparam int S_FLUSH = 2;
    localparam int S_RV    = 1;
    localparam int S_BUSY  = 0;
    localparam int S_PERF_STALL = 8;
    localparam int S_PERF_KILL  = 9;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       MdValidE = 1'b0;
    logic [1:0] MdOpE = 2'b00;
    logic       DivZeroE = 1'b0;
    logic       KillE = 1'b0;
    logic       MdStart, MdAbort, MdStallF, MdStallD, MdStallE, MdFlushM, MdResultValidE, MdBusy;
`ifdef MULDIV_PERF_EN
    logic [31:0] MdStallCycles;
    logic [15:0] MdKillCount;
`endif

    muldiv_stall_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(6)) dut (
        .clk           (clk),
        .reset         (reset),
        .MdValidE      (MdValidE),
        .MdOpE         (MdOpE),
        .DivZeroE      (DivZeroE),
        .KillE         (KillE),
        .MdStart       (MdStart),
        .MdAbort       (MdAbort),
        .MdStallF      (MdStallF),
        .MdStallD      (MdStallD),
        .MdStallE      (MdStallE),
        .MdFlushM      (MdFlushM),
        .MdResultValidE(MdResultValidE),
        .MdBusy        (MdBusy)
`ifdef MULDIV_PERF_EN
        ,
        .MdStallCycles (MdStallCycles),
        .MdKillCount   (MdKillCount)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    typedef struct {
        string   name;
        int      sel;
        longint  val;
    } lit_t;
    lit_t litQ[$];

    // Model: an op occupies EX from its start cycle; it completes lat cycles later unless killed.
    int  cyc = 0;
    bit  inFlight = 1'b0;
    bit  dead = 1'b0;
    int  startCyc = 0;
    int  lat = 0;
    longint stallModel = 0;
    longint killModel = 0;

    function automatic int tbLat(logic [1:0] op, logic dz);
        if (op == 2'd1 || op == 2'd2) return dz ? 1 : int'(DIV_LAT);
        return int'(MUL_LAT);
    endfunction

    function automatic logic [7:0] expOut(bit rst, bit inF, bit dd, int age, int lt, bit v, bit k);
        bit st, ab, sl, rv, bz;
        st = 0; ab = 0; sl = 0; rv = 0; bz = 0;
        if (!rst) begin
            if (dd) begin
                bz = 1;
            end else if (inF) begin
                bz = 1;
                if (k) begin
                    ab = 1;
                    sl = 1;
                end else if (age >= lt) begin
                    rv = 1;
                end else begin
                    sl = 1;
                end
            end else if (v && !k) begin
                st = 1;
                sl = 1;
            end
        end
        return {st, ab, sl, sl, sl, sl, rv, bz};
    endfunction

    always @(posedge clk or posedge reset) begin
        logic [7:0] e;
        if (reset) begin
            inFlight   <= 1'b0;
            dead       <= 1'b0;
            stallModel <= 0;
            killModel  <= 0;
        end else begin
            e = expOut(1'b0, inFlight, dead, cyc - startCyc, lat, MdValidE, KillE);
            cyc  <= cyc + 1;
            dead <= 1'b0;
            if (e[S_STALL]) stallModel <= stallModel + 1;
            if (e[S_ABORT]) killModel <= killModel + 1;
            if (dead) begin
                inFlight <= 1'b0;
            end else if (inFlight) begin
                if (KillE) begin
                    inFlight <= 1'b0;
                    dead     <= 1'b1;
                end else if (cyc - startCyc >= lat) begin
                    inFlight <= 1'b0;
                end
            end else if (MdValidE && !KillE) begin
                inFlight <= 1'b1;
                startCyc <= cyc;
                lat      <= tbLat(MdOpE, DivZeroE);
            end
        end
    end

    // Single compare point: full output vector every cycle plus queued literal expectations.
    always @(negedge clk) begin
        logic [7:0] act, e;
        longint a;
        lit_t l;
        if (started) begin
            act = {MdStart, MdAbort, MdStallF, MdStallD, MdStallE, MdFlushM, MdResultValidE, MdBusy};
            e   = expOut(reset, inFlight, dead, cyc - startCyc, lat, MdValidE, KillE);
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL outputs t=%0t got=%b want=%b (start,abort,sF,sD,sE,flush,rv,busy)", $time, act, e);
            end
`ifdef MULDIV_PERF_EN
            checks++;
            if (longint'(MdStallCycles) != stallModel || longint'(MdKillCount) != killModel) begin
                errors++;
                $display("FAIL perf t=%0t got=%0d/%0d want=%0d/%0d", $time,
                         MdStallCycles, MdKillCount, stallModel, killModel);
            end
`endif
            while (litQ.size() > 0) begin
                l = litQ.pop_front();
                if (l.sel == S_PERF_STALL) begin
`ifdef MULDIV_PERF_EN
                    a = longint'(MdStallCycles);
`else
                    a = l.val;
`endif
                end else if (l.sel == S_PERF_KILL) begin
`ifdef MULDIV_PERF_EN
                    a = longint'(MdKillCount);
`else
                    a = l.val;
`endif
                end else begin
                    a = longint'(act[l.sel]);
                end
                checks++;
                if (a != l.val) begin
                    errors++;
                    $display("FAIL %s t=%0t got=%0d want=%0d", l.name, $time, a, l.val);
                end
            end
        end
    end

    task automatic want(string name, int sel, longint val);
        lit_t l;
        l.name = name;
        l.sel  = sel;
        l.val  = val;
        litQ.push_back(l);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(bit v, logic [1:0] op, bit dz, bit k);
        MdValidE = v;
        MdOpE    = op;
        DivZeroE = dz;
        KillE    = k;
    endtask

    initial begin
        started = 1'b1;
        want("rst_busy", S_BUSY, 0);
        want("rst_stall", S_STALL, 0);
        step();
        step();
        reset = 1'b0;
        want("idle_busy", S_BUSY, 0);
        step();

        // MUL, latency 3
        drive(1, 2'd0, 0, 0);
        want("mul_start_c0", S_START, 1);
        want("mul_stall_c0", S_STALL, 1);
        step();
        want("mul_start_c1", S_START, 0);
        want("mul_stall_c1", S_STALL, 1);
        step();
        want("mul_stall_c2", S_STALL, 1);
        step();
        want("mul_rv_c3", S_RV, 1);
        want("mul_stall_c3", S_STALL, 0);
        step();
        drive(0, 2'd0, 0, 0);
        want("mul_busy_c4", S_BUSY, 0);
        step();

        // DIV killed at cycle 10
        drive(1, 2'd1, 0, 0);
        repeat (10) step();
        KillE = 1'b1;
        want("kill_abort", S_ABORT, 1);
        want("kill_stall", S_STALL, 1);
        want("kill_rv", S_RV, 0);
        step();
        KillE = 1'b0;
        want("abort_stall", S_STALL, 0);
        want("abort_start", S_START, 0);
        want("abort_busy", S_BUSY, 1);
        want("abort_abort", S_ABORT, 0);
        step();
        drive(0, 2'd0, 0, 0);
        want("post_abort_busy", S_BUSY, 0);
`ifdef MULDIV_PERF_EN
        want("perf_stall_cycles", S_PERF_STALL, 14);
        want("perf_kill_count", S_PERF_KILL, 1);
`endif
        step();

        // DIV by zero, latency 1
        drive(1, 2'd1, 1, 0);
        want("dz_stall_c0", S_STALL, 1);
        step();
        want("dz_rv_c1", S_RV, 1);
        want("dz_stall_c1", S_STALL, 0);
        step();
        drive(0, 2'd0, 0, 0);
        want("dz_busy_c2", S_BUSY, 0);
        step();

        // MUL then back-to-back REM
        drive(1, 2'd0, 0, 0);
        step();
        step();
        step();
        want("b2b_rv_c3", S_RV, 1);
        want("b2b_nostart_c3", S_START, 0);
        step();
        drive(1, 2'd2, 0, 0);
        want("b2b_start_c4", S_START, 1);
        repeat (32) step();
        want("rem_rv", S_RV, 1);
        step();
        drive(0, 2'd0, 0, 0);
        step();

        // Reset during DIV BUSY cycle 5
        drive(1, 2'd1, 0, 0);
        repeat (5) step();
        reset = 1'b1;
        want("arst_stall", S_STALL, 0);
        want("arst_busy", S_BUSY, 0);
        want("arst_flush", S_FLUSH, 0);
        step();
        reset = 1'b0;
        drive(0, 2'd0, 0, 0);
        want("arst_idle", S_BUSY, 0);
        step();
        want("arst_idle2", S_START, 0);
        step();

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            drive(($urandom % 4) != 0, 2'($urandom % 4), ($urandom % 5) == 0, ($urandom % 32) == 0);
            reset = (($urandom % 256) == 0);
            step();
        end
        reset = 1'b0;
        drive(0, 2'd0, 0, 0);
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
